pkt_stream_driver: RTL and testbench

//  Parametrised stimulus driver sitting between the DPI packet source and the DUT BFM in sim wrappers.

---
 rtl/stim_pkg.sv | 17 +
 rtl/pkt_fifo.sv | 54 +++++
 rtl/pkt_stream_driver.sv | 148 ++++++++++++++
 tb/tb_pkt_stream_driver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared types and helpers for the packet stream driver
package stim_pkg;

   // Driver life cycle: wait for start, load+emit, emit what is left, hold quiet.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } drv_state_e;

   // Counter width that stays legal when a packet has a single word.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - synchronous FIFO of whole packets with head-of-queue view
module pkt_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic clr_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output T     head_o
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit tells a full FIFO apart from an empty one.
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   T            mem_q [DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; a push into a full FIFO is dropped even if a pop happens alongside.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_i && !empty_o) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Packet storage; entries are always written before the read pointer reaches them.
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/pkt_stream_driver.sv
// rtl/pkt_stream_driver.sv - buffers whole packets and serialises them onto a word stream
module pkt_stream_driver
   import stim_pkg::*;
#(
   parameter int WORD_W        = 255,
   parameter int WORDS_PER_PKT = 3,
   parameter int NUM_PKTS      = 10,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_ni,
   input  logic                             start_i,
   input  logic                             pkt_valid_i,
   output logic                             pkt_ready_o,
   input  logic [WORDS_PER_PKT*WORD_W-1:0]  pkt_data_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [WORD_W-1:0]                out_data_o,
   output logic                             out_last_o,
   output logic [$clog2(NUM_PKTS+1)-1:0]    pkt_cnt_o,
   output logic                             busy_o,
   output logic                             done_o
);

   localparam int CW = $clog2(NUM_PKTS + 1);
   localparam int IW = idx_width(WORDS_PER_PKT);

   localparam logic [CW-1:0] NUM_C    = CW'(NUM_PKTS);
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PKTS - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WORDS_PER_PKT - 1);

   typedef logic [WORD_W-1:0]          word_t;
   typedef word_t [WORDS_PER_PKT-1:0]  pkt_t;

   drv_state_e    state_q;
   drv_state_e    state_d;
   logic [CW-1:0] loaded_q;
   logic [CW-1:0] pkt_cnt_q;
   logic [IW-1:0] idx_q;

   logic fifo_full;
   logic fifo_empty;
   logic clr;
   logic push;
   logic beat;
   logic pop;
   logic last_word;
   logic busy;
   pkt_t pkt_in;
   pkt_t head;

   assign pkt_in    = pkt_data_i;
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign clr       = start_i && ((state_q == IDLE) || (state_q == DONE));

   // Ready depends only on registered state, so a same-cycle pop never frees a slot early.
   assign pkt_ready_o = (state_q == RUN) && !fifo_full && (loaded_q != NUM_C);
   assign push        = pkt_valid_i && pkt_ready_o;

   assign last_word   = (idx_q == IDX_LAST);
   assign out_valid_o = busy && !fifo_empty;
   assign out_data_o  = out_valid_o ? head[idx_q] : '0;
   assign out_last_o  = out_valid_o && last_word;
   assign beat        = out_valid_o && out_ready_i;
   assign pop         = beat && last_word;

   assign pkt_cnt_o = pkt_cnt_q;
   assign busy_o    = busy;
   assign done_o    = (state_q == DONE);

   pkt_fifo #(
      .T     (pkt_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clr_i    (clr),
      .push_i   (push),
      .data_i   (pkt_in),
      .pop_i    (pop),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .head_o   (head)
   );

   // State register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; the final packet can finish while still in RUN when packets are one word long.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (pop && (pkt_cnt_q == LAST_CNT)) begin
               state_d = DONE;
            end else if (loaded_q == NUM_C) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (pkt_cnt_q == LAST_CNT)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (start_i) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Loaded/emitted packet counters and the word index inside the head packet.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         loaded_q  <= '0;
         pkt_cnt_q <= '0;
         idx_q     <= '0;
      end else if (clr) begin
         loaded_q  <= '0;
         pkt_cnt_q <= '0;
         idx_q     <= '0;
      end else begin
         if (push) begin
            loaded_q <= loaded_q + 1'b1;
         end
         if (beat) begin
            idx_q <= last_word ? '0 : idx_q + 1'b1;
         end
         if (pop) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pkt_stream_driver.sv
// tb/tb_pkt_stream_driver.sv - self-checking bench for pkt_stream_driver
module tb_pkt_stream_driver;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic        start;
   logic        pkt_valid;
   logic [47:0] pkt_data;
   logic        out_ready;

   logic        a_ready, a_valid, a_last, a_busy, a_done;
   logic [15:0] a_data;
   logic [1:0]  a_cnt;
   logic        b_ready, b_valid, b_last, b_busy, b_done;
   logic [15:0] b_data;
   logic [2:0]  b_cnt;
   logic        c_ready, c_valid, c_last, c_busy, c_done;
   logic [15:0] c_data;
   logic [6:0]  c_cnt;

   logic        obs_ready, obs_valid, obs_last, obs_busy, obs_done;
   logic [15:0] obs_data;
   logic [6:0]  obs_cnt;

   int          sel;
   int          nwpp;
   int          nnum;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [15:0] exp_q[$];
   logic [47:0] src_q[$];
   int          loaded_m, emitted_m, beat_m, beats_tot;
   bit          started;
   bit          rnd_rdy;

   always #5 clk = ~clk;

   pkt_stream_driver #(.WORD_W(16), .WORDS_PER_PKT(3), .NUM_PKTS(2), .FIFO_DEPTH(4)) u_a (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .pkt_valid_i(pkt_valid),
      .pkt_ready_o(a_ready), .pkt_data_i(pkt_data), .out_valid_o(a_valid),
      .out_ready_i(out_ready), .out_data_o(a_data), .out_last_o(a_last),
      .pkt_cnt_o(a_cnt), .busy_o(a_busy), .done_o(a_done));

   pkt_stream_driver #(.WORD_W(16), .WORDS_PER_PKT(3), .NUM_PKTS(6), .FIFO_DEPTH(4)) u_b (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .pkt_valid_i(pkt_valid),
      .pkt_ready_o(b_ready), .pkt_data_i(pkt_data), .out_valid_o(b_valid),
      .out_ready_i(out_ready), .out_data_o(b_data), .out_last_o(b_last),
      .pkt_cnt_o(b_cnt), .busy_o(b_busy), .done_o(b_done));

   pkt_stream_driver #(.WORD_W(16), .WORDS_PER_PKT(1), .NUM_PKTS(100), .FIFO_DEPTH(4)) u_c (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .pkt_valid_i(pkt_valid),
      .pkt_ready_o(c_ready), .pkt_data_i(pkt_data[15:0]), .out_valid_o(c_valid),
      .out_ready_i(out_ready), .out_data_o(c_data), .out_last_o(c_last),
      .pkt_cnt_o(c_cnt), .busy_o(c_busy), .done_o(c_done));

   // Route the instance under test onto one set of observation signals.
   always_comb begin
      obs_ready = a_ready; obs_valid = a_valid; obs_last = a_last;
      obs_busy  = a_busy;  obs_done  = a_done;  obs_data = a_data;
      obs_cnt   = {5'd0, a_cnt};
      if (sel == 1) begin
         obs_ready = b_ready; obs_valid = b_valid; obs_last = b_last;
         obs_busy  = b_busy;  obs_done  = b_done;  obs_data = b_data;
         obs_cnt   = {4'd0, b_cnt};
      end else if (sel == 2) begin
         obs_ready = c_ready; obs_valid = c_valid; obs_last = c_last;
         obs_busy  = c_busy;  obs_done  = c_done;  obs_data = c_data;
         obs_cnt   = c_cnt;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference view: packets in flight = accepted minus fully emitted, FIFO holds 4.
   function automatic bit m_done();
      return started && (emitted_m == nnum);
   endfunction

   function automatic bit m_ready();
      return started && (loaded_m < nnum) && ((loaded_m - emitted_m) < 4);
   endfunction

   function automatic bit m_valid();
      return started && ((loaded_m - emitted_m) > 0);
   endfunction

   task automatic step();
      bit          e_ready, e_valid, e_last;
      logic [47:0] p;
      @(negedge clk);
      e_ready = m_ready();
      e_valid = m_valid();
      e_last  = (beat_m == nwpp - 1);
      chk("pkt_ready_o", obs_ready, e_ready);
      chk("out_valid_o", obs_valid, e_valid);
      chk("done_o", obs_done, m_done());
      chk("busy_o", obs_busy, started && !m_done());
      chk("pkt_cnt_o", obs_cnt, emitted_m);
      if (e_valid && exp_q.size() > 0) begin
         chk("out_data_o", obs_data, exp_q[0]);
         chk("out_last_o", obs_last, e_last);
         if (out_ready) begin
            void'(exp_q.pop_front());
            beats_tot++;
            beat_m++;
            if (beat_m == nwpp) begin
               beat_m = 0;
               emitted_m++;
            end
         end
      end else begin
         chk("out_last_idle", obs_last, 1'b0);
      end
      if (pkt_valid && e_ready && src_q.size() > 0) begin
         p = src_q.pop_front();
         for (int k = 0; k < nwpp; k++) exp_q.push_back(p[k*16 +: 16]);
         loaded_m++;
      end
      if (start && (!started || m_done())) begin
         started   = 1'b1;
         loaded_m  = 0;
         emitted_m = 0;
         beat_m    = 0;
         beats_tot = 0;
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      pkt_valid = (src_q.size() > 0);
      pkt_data  = (src_q.size() > 0) ? src_q[0] : 48'd0;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic pulse_start();
      pkt_valid = (src_q.size() > 0);
      pkt_data  = (src_q.size() > 0) ? src_q[0] : 48'd0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      #2;
      chk("rst out_valid_o", obs_valid, 1'b0);
      chk("rst out_last_o", obs_last, 1'b0);
      chk("rst out_data_o", obs_data, 16'd0);
      chk("rst pkt_ready_o", obs_ready, 1'b0);
      chk("rst pkt_cnt_o", obs_cnt, 7'd0);
      chk("rst busy_o", obs_busy, 1'b0);
      chk("rst done_o", obs_done, 1'b0);
      started = 1'b0; loaded_m = 0; emitted_m = 0; beat_m = 0; beats_tot = 0;
      exp_q.delete();
      src_q.delete();
      pkt_valid = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset_ni = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!m_done() && n < budget) begin
         step();
         n++;
      end
      chk("done within budget", n < budget, 1'b1);
      chk("done_o final", obs_done, 1'b1);
      chk("stream drained", exp_q.size(), 0);
   endtask

   function automatic logic [47:0] rnd_pkt();
      return {16'($urandom), 16'($urandom), 16'($urandom)};
   endfunction

   initial begin
      int n;
      start = 0; pkt_valid = 0; pkt_data = '0; out_ready = 0; rnd_rdy = 0;
      reset_ni = 1'b0;
      sel = 0; nwpp = 3; nnum = 2;
      do_reset();
      repeat (2) step();

      // Two fixed packets, sink always ready.
      src_q.push_back({16'h0033, 16'h0022, 16'h0011});
      src_q.push_back({16'h0066, 16'h0055, 16'h0044});
      out_ready = 1'b1;
      pulse_start();
      wait_done(40);
      chk("t1 beats", beats_tot, 6);
      chk("t1 pkt_cnt_o", obs_cnt, 7'd2);

      // Restart from DONE, stall the sink mid-packet, poke start while running.
      src_q.push_back(rnd_pkt());
      src_q.push_back(rnd_pkt());
      pulse_start();
      n = 0;
      while (beats_tot < 1 && n < 20) begin step(); n++; end
      chk("t2 first beat seen", n < 20, 1'b1);
      out_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("t2 held valid", obs_valid, 1'b1);
      out_ready = 1'b1;
      wait_done(40);
      chk("t2 pkt_cnt_o", obs_cnt, 7'd2);

      // Reset while on word 1 of packet 2, then restart from scratch.
      src_q.push_back(rnd_pkt());
      src_q.push_back(rnd_pkt());
      pulse_start();
      n = 0;
      while (!(emitted_m == 1 && beat_m == 1) && n < 20) begin step(); n++; end
      chk("t4 reached idx1", n < 20, 1'b1);
      chk("t4 pkt_cnt before reset", obs_cnt, 7'd1);
      do_reset();
      src_q.push_back(rnd_pkt());
      src_q.push_back(rnd_pkt());
      pulse_start();
      wait_done(40);

      // Deep instance: sink blocked, six packets offered, FIFO fills at four.
      sel = 1; nwpp = 3; nnum = 6;
      do_reset();
      for (int i = 0; i < 6; i++) src_q.push_back(rnd_pkt());
      out_ready = 1'b0;
      pulse_start();
      repeat (10) step();
      chk("t3 ready low when full", obs_ready, 1'b0);
      chk("t3 offered left", src_q.size(), 2);
      out_ready = 1'b1;
      n = 0;
      while (loaded_m < 5 && n < 20) begin step(); n++; end
      chk("t3 fifth accepted", n < 20, 1'b1);
      chk("t3 fifth after one pop", obs_cnt, 7'd1);
      wait_done(100);
      chk("t3 pkt_cnt_o", obs_cnt, 7'd6);

      // Single-word packets with random back-pressure.
      sel = 2; nwpp = 1; nnum = 100;
      do_reset();
      void'($urandom(1));
      for (int i = 0; i < 100; i++) src_q.push_back({32'd0, 16'($urandom)});
      rnd_rdy = 1'b1;
      out_ready = 1'b1;
      pulse_start();
      wait_done(2000);
      chk("t6 pkt_cnt_o", obs_cnt, 7'd100);
      chk("t6 beats", beats_tot, 100);
      rnd_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
